idma_legalizer_burst_sequencer: RTL and testbench
=================================================

// Module: idma_legalizer_burst_sequencer
// PURPOSE
//  Sequences the page-splitter datapath: accepts one 1D transfer (src, dst, length) per handshake and
//  emits a stream of legal bursts, each bounded by remaining length, src page boundary and dst page boundary.
//  Sits between the frontend request queue and the read/write backend issue ports.
//  One transfer in flight; next request accepted only after the last burst of the current one is handed off.
// PARAMETERS
//  AddrWidth      32  address and length width (bytes)
//  OffsetWidth    2   log2(bus width in bytes); page base when not bursting
//  PageAddrWidth  12  max page offset bits (4 KiB AXI boundary)
// PORTS
//  clk_i                 in   1              clock
//  rst_i                 in   1              synchronous reset, active-high
//  req_valid_i           in   1              transfer request valid
//  req_ready_o           out  1              transfer request ready
//  req_src_addr_i        in   AddrWidth      source start address
//  req_dst_addr_i        in   AddrWidth      destination start address
//  req_length_i          in   AddrWidth      transfer length in bytes
//  req_src_not_burst_i   in   1              src side: no bursting (page = 1 beat)
//  req_src_reduce_len_i  in   1              src side: apply max_llen constraint
//  req_src_max_llen_i    in   3              src side: log2 max beats
//  req_dst_not_burst_i   in   1              dst side: same as src
//  req_dst_reduce_len_i  in   1              dst side
//  req_dst_max_llen_i    in   3              dst side
//  burst_valid_o         out  1              burst valid
//  burst_ready_i         in   1              burst accepted by backend
//  burst_src_addr_o      out  AddrWidth      burst source address
//  burst_dst_addr_o      out  AddrWidth      burst destination address
//  burst_len_o           out  AddrWidth      burst length in bytes, never 0
//  burst_last_o          out  1              final burst of the transfer
//  busy_o                out  1              transfer in progress
// BEHAVIOUR
//  - Reset (rst_i=1 at a clk_i edge): state IDLE, all registers 0; combinationally while rst_i=1:
//    req_ready_o=0, burst_valid_o=0, busy_o=0, burst_* data 0. Reset mid-transfer drops it; no further bursts.
//  - FSM IDLE: req_ready_o=1, burst_valid_o=0, busy_o=0. On req_valid_i&&req_ready_o: capture all req_* fields;
//    length==0 -> stay IDLE (request consumed, nothing emitted); else -> BURST.
//  - FSM BURST: req_ready_o=0, busy_o=1, burst_valid_o=1. First burst valid the cycle after acceptance.
//    src_pb/dst_pb = bytes to page boundary from current src/dst address (page splitter, per-side config).
//    burst_len_o = min(rem, src_pb, dst_pb); burst_last_o = (burst_len_o == rem).
//    On burst_valid_o&&burst_ready_i: src+=len, dst+=len, rem-=len; if last -> IDLE, else stay BURST.
//    Next burst presented the following cycle (one burst per cycle max under ready=1).
//  - Outputs are functions of registered state only; stable while burst_valid_o && !burst_ready_i.
//  - Widths: page lengths PageAddrWidth+1 bits, zero-extended to AddrWidth before min; address adds wrap
//    modulo 2^AddrWidth (no error flagged).
//  - Page size per side = 2^min(OffsetWidth + (reduce ? max_llen : 8), 12); not_burst -> 2^OffsetWidth.
//  - No combinational path from req_* inputs to burst_* outputs; burst_ready_i affects only state.
// STRUCTURE
//  - Package idma_legalizer_pkg: addr_t, len_t (AddrWidth), page_len_t (PageAddrWidth+1), page_addr_t
//    (PageAddrWidth), state enum {IDLE, BURST}, side config struct {not_burst, reduce_len, max_llen}.
//  - Two instances of idma_legalizer_page_splitter (src, dst); FSM, counters, min logic local.
// TESTING (OffsetWidth=2, PageAddrWidth=12, AddrWidth=32, burst_ready_i=1 unless stated)
//  1 src=0x0 dst=0x0 len=0x100, no reduce -> one burst len 0x100 @0x0/0x0, last=1; ready=1 next cycle.
//  2 src=0x3F0 dst=0x1000 len=0x40 -> 0x10 @0x3F0/0x1000 last=0; 0x30 @0x400/0x1010 last=1.
//  3 src reduce max_llen=2 (16 B page), src=0x0 dst=0x8 len=0x20 -> 0x10 @0x0/0x8; 0x10 @0x10/0x18 last.
//  4 src not_burst, src=0x2 dst=0x100 len=6 -> 2 @0x2/0x100; 4 @0x4/0x102 last; case 2 with ready low
//    5 cycles per burst -> all burst_* outputs unchanged while stalled, same burst sequence.
//  5 len=0 request -> accepted, no burst_valid_o, busy_o stays 0, req_ready_o=1 next cycle.
//  6 rst_i=1 during case 2 after first burst -> burst_valid_o=0 next cycle, IDLE, new request accepted normally.

Source files
------------

// File: rtl/idma_legalizer_pkg.sv
// Shared types for the iDMA legalizer burst sequencer.
// Holds the datapath widths, the FSM state enum, the per-side page
// configuration struct and a small min helper used by the burst-length logic.
package idma_legalizer_pkg;

    localparam int unsigned AddrWidth     = 32;  // address and length width in bytes
    localparam int unsigned OffsetWidth   = 2;   // log2 of the bus width in bytes
    localparam int unsigned PageAddrWidth = 12;  // 4 KiB AXI boundary

    typedef logic [AddrWidth-1:0]     addr_t;
    typedef logic [AddrWidth-1:0]     len_t;
    typedef logic [PageAddrWidth:0]   page_len_t;   // one extra bit so a full page fits
    typedef logic [PageAddrWidth-1:0] page_addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Page configuration of one side (source or destination).
    typedef struct packed {
        logic       not_burst;   // page shrinks to a single bus beat
        logic       reduce_len;  // page limited to 2^max_llen beats
        logic [2:0] max_llen;    // log2 of the maximum beat count
    } side_cfg_t;

    function automatic len_t min_len(input len_t a, input len_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/idma_legalizer_page_splitter.sv
// Page splitter for one side of a transfer.
// Computes how many bytes remain from the current address up to the next
// page boundary, where the page size depends on the side configuration:
//   not_burst          -> 2^OffsetWidth (one beat)
//   otherwise          -> 2^min(OffsetWidth + (reduce_len ? max_llen : 8), PageAddrWidth)
// Ports:
//   addr_i               in   low PageAddrWidth bits of the current address
//   cfg_i                in   side configuration
//   bytes_to_boundary_o  out  bytes up to the page boundary, always >= 1
module idma_legalizer_page_splitter
    import idma_legalizer_pkg::*;
(
    input  page_addr_t addr_i,
    input  side_cfg_t  cfg_i,
    output page_len_t  bytes_to_boundary_o
);

    logic [4:0] log_size;
    page_len_t  page_size;
    page_len_t  page_off;

    always_comb begin
        log_size = 5'(OffsetWidth);
        if (!cfg_i.not_burst) begin
            if (cfg_i.reduce_len) begin
                log_size = 5'(OffsetWidth) + 5'(cfg_i.max_llen);
            end else begin
                log_size = 5'(OffsetWidth + 8);
            end
            // Never cross the 4 KiB boundary regardless of the beat count.
            if (log_size > 5'(PageAddrWidth)) begin
                log_size = 5'(PageAddrWidth);
            end
        end
    end

    assign page_size           = page_len_t'(1) << log_size;
    assign page_off            = page_len_t'(addr_i) & (page_size - page_len_t'(1));
    assign bytes_to_boundary_o = page_size - page_off;

endmodule

// File: rtl/idma_legalizer_burst_sequencer.sv
// Burst sequencer of the iDMA legalizer.
// Accepts one 1D transfer (src, dst, length) per request handshake and emits
// legal bursts, each bounded by the remaining length and by the src and dst
// page boundaries. Only one transfer is in flight at a time.
//
// Handshakes: both req_* and burst_* use valid/ready. A transfer moves when
// valid && ready are high at a rising clk_i edge; a valid burst holds all its
// data stable until it is taken, and burst_* never depends on req_* or
// burst_ready_i combinationally.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_valid_i/req_ready_o  transfer request handshake
//   req_src/dst_addr_i       transfer start addresses
//   req_length_i             transfer length in bytes (0 = consumed, no bursts)
//   req_src/dst_*_i          per-side page configuration
//   burst_valid_o/ready_i    burst handshake towards the backend
//   burst_src/dst_addr_o     burst start addresses
//   burst_len_o              burst length in bytes, never 0 while valid
//   burst_last_o             final burst of the transfer
//   busy_o                   transfer in progress
//   dbg_state_o              current FSM state for observation
module idma_legalizer_burst_sequencer
    import idma_legalizer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  addr_t      req_src_addr_i,
    input  addr_t      req_dst_addr_i,
    input  len_t       req_length_i,
    input  logic       req_src_not_burst_i,
    input  logic       req_src_reduce_len_i,
    input  logic [2:0] req_src_max_llen_i,
    input  logic       req_dst_not_burst_i,
    input  logic       req_dst_reduce_len_i,
    input  logic [2:0] req_dst_max_llen_i,
    output logic       burst_valid_o,
    input  logic       burst_ready_i,
    output addr_t      burst_src_addr_o,
    output addr_t      burst_dst_addr_o,
    output len_t       burst_len_o,
    output logic       burst_last_o,
    output logic       busy_o,
    output state_e     dbg_state_o
);

    state_e    state_q, state_d;
    addr_t     src_q, src_d;
    addr_t     dst_q, dst_d;
    len_t      rem_q, rem_d;
    side_cfg_t src_cfg_q, src_cfg_d;
    side_cfg_t dst_cfg_q, dst_cfg_d;

    page_len_t src_pb;
    page_len_t dst_pb;
    len_t      cur_len;
    logic      cur_last;

    idma_legalizer_page_splitter u_src_splitter (
        .addr_i              (src_q[PageAddrWidth-1:0]),
        .cfg_i               (src_cfg_q),
        .bytes_to_boundary_o (src_pb)
    );

    idma_legalizer_page_splitter u_dst_splitter (
        .addr_i              (dst_q[PageAddrWidth-1:0]),
        .cfg_i               (dst_cfg_q),
        .bytes_to_boundary_o (dst_pb)
    );

    assign cur_len  = min_len(rem_q, min_len(len_t'(src_pb), len_t'(dst_pb)));
    assign cur_last = (cur_len == rem_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            src_cfg_q <= '0;
            dst_cfg_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            src_cfg_q <= src_cfg_d;
            dst_cfg_q <= dst_cfg_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        rem_d         = rem_q;
        src_cfg_d     = src_cfg_q;
        dst_cfg_d     = dst_cfg_q;
        req_ready_o   = 1'b0;
        burst_valid_o = 1'b0;
        busy_o        = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    src_d     = req_src_addr_i;
                    dst_d     = req_dst_addr_i;
                    rem_d     = req_length_i;
                    src_cfg_d = '{req_src_not_burst_i, req_src_reduce_len_i, req_src_max_llen_i};
                    dst_cfg_d = '{req_dst_not_burst_i, req_dst_reduce_len_i, req_dst_max_llen_i};
                    // A zero-length request is consumed without emitting anything.
                    if (req_length_i != '0) begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                busy_o        = 1'b1;
                burst_valid_o = 1'b1;
                if (burst_ready_i) begin
                    src_d = src_q + cur_len;
                    dst_d = dst_q + cur_len;
                    rem_d = rem_q - cur_len;
                    if (cur_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // While reset is asserted the block presents a quiet interface.
        if (rst_i) begin
            req_ready_o   = 1'b0;
            burst_valid_o = 1'b0;
            busy_o        = 1'b0;
        end
    end

    assign burst_src_addr_o = rst_i ? '0 : src_q;
    assign burst_dst_addr_o = rst_i ? '0 : dst_q;
    assign burst_len_o      = rst_i ? '0 : cur_len;
    assign burst_last_o     = rst_i ? 1'b0 : cur_last;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_idma_legalizer_burst_sequencer.sv
module tb_idma_legalizer_burst_sequencer;
    import idma_legalizer_pkg::*;

    localparam int W = 97;  // {src, dst, len, last}

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        logic        snb;
        logic        srl;
        logic [2:0]  sml;
        logic        dnb;
        logic        drl;
        logic [2:0]  dml;
    } req_t;

    typedef struct packed {
        req_t            req;
        logic [1:0]      n;
        logic [1:0][W-1:0] exp;
        logic [7:0]      stall;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_src_addr_i = '0;
    logic [31:0] req_dst_addr_i = '0;
    logic [31:0] req_length_i = '0;
    logic        req_src_not_burst_i = 1'b0;
    logic        req_src_reduce_len_i = 1'b0;
    logic [2:0]  req_src_max_llen_i = '0;
    logic        req_dst_not_burst_i = 1'b0;
    logic        req_dst_reduce_len_i = 1'b0;
    logic [2:0]  req_dst_max_llen_i = '0;
    logic        burst_valid_o;
    logic        burst_ready_i = 1'b1;
    logic [31:0] burst_src_addr_o;
    logic [31:0] burst_dst_addr_o;
    logic [31:0] burst_len_o;
    logic        burst_last_o;
    logic        busy_o;
    state_e      dbg_state_o;

    idma_legalizer_burst_sequencer dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .req_valid_i          (req_valid_i),
        .req_ready_o          (req_ready_o),
        .req_src_addr_i       (req_src_addr_i),
        .req_dst_addr_i       (req_dst_addr_i),
        .req_length_i         (req_length_i),
        .req_src_not_burst_i  (req_src_not_burst_i),
        .req_src_reduce_len_i (req_src_reduce_len_i),
        .req_src_max_llen_i   (req_src_max_llen_i),
        .req_dst_not_burst_i  (req_dst_not_burst_i),
        .req_dst_reduce_len_i (req_dst_reduce_len_i),
        .req_dst_max_llen_i   (req_dst_max_llen_i),
        .burst_valid_o        (burst_valid_o),
        .burst_ready_i        (burst_ready_i),
        .burst_src_addr_o     (burst_src_addr_o),
        .burst_dst_addr_o     (burst_dst_addr_o),
        .burst_len_o          (burst_len_o),
        .burst_last_o         (burst_last_o),
        .busy_o               (busy_o),
        .dbg_state_o          (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_burst(input logic [31:0] s, input logic [31:0] d,
                                              input logic [31:0] l, input logic last);
        return {s, d, l, last};
    endfunction

    function automatic req_t mk_req(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                                    input logic snb, input logic srl, input logic [2:0] sml,
                                    input logic dnb, input logic drl, input logic [2:0] dml);
        req_t r;
        r.src = s; r.dst = d; r.len = l;
        r.snb = snb; r.srl = srl; r.sml = sml;
        r.dnb = dnb; r.drl = drl; r.dml = dml;
        return r;
    endfunction

    // ---------------- reference model ----------------
    // Bytes to the next page boundary, straight from the page-size rule.
    function automatic logic [31:0] page_bytes(input logic [31:0] addr, input logic nb,
                                               input logic rl, input logic [2:0] ll);
        int unsigned lg;
        int unsigned size;
        if (nb) lg = 2;
        else begin
            lg = 2 + (rl ? int'(ll) : 8);
            if (lg > 12) lg = 12;
        end
        size = 1 << lg;
        return size - (addr % size);
    endfunction

    function automatic void model(input req_t r);
        logic [31:0] s, d, rem, l, ps, pd;
        s = r.src; d = r.dst; rem = r.len;
        while (rem != 0) begin
            ps = page_bytes(s, r.snb, r.srl, r.sml);
            pd = page_bytes(d, r.dnb, r.drl, r.dml);
            l = rem;
            if (ps < l) l = ps;
            if (pd < l) l = pd;
            exp_q.push_back(mk_burst(s, d, l, l == rem));
            s = s + l; d = d + l; rem = rem - l;
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic send_req(input req_t r);
        int guard = 0;
        while (req_ready_o !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_before_req", req_ready_o, 1);
        req_valid_i          = 1'b1;
        req_src_addr_i       = r.src;
        req_dst_addr_i       = r.dst;
        req_length_i         = r.len;
        req_src_not_burst_i  = r.snb;
        req_src_reduce_len_i = r.srl;
        req_src_max_llen_i   = r.sml;
        req_dst_not_burst_i  = r.dnb;
        req_dst_reduce_len_i = r.drl;
        req_dst_max_llen_i   = r.dml;
        @(negedge clk);
        // Scramble the request fields: the captured copy must be used from now on.
        req_valid_i    = 1'b0;
        req_src_addr_i = $urandom();
        req_dst_addr_i = $urandom();
        req_length_i   = $urandom();
        req_src_max_llen_i = 3'($urandom_range(0, 7));
        req_dst_max_llen_i = 3'($urandom_range(0, 7));
    endtask

    // Expects each queued burst to be presented on consecutive cycles.
    task automatic collect(input int stall);
        logic [W-1:0] got;
        logic [W-1:0] e;
        int idx = 0;
        while (exp_q.size() > 0) begin
            check($sformatf("burst_valid[%0d]", idx), {burst_valid_o, busy_o, req_ready_o}, 3'b110);
            if (burst_valid_o !== 1'b1) begin
                exp_q.delete();
                break;
            end
            got = {burst_src_addr_o, burst_dst_addr_o, burst_len_o, burst_last_o};
            if (stall > 0) begin
                burst_ready_i = 1'b0;
                repeat (stall) begin
                    @(negedge clk);
                    check($sformatf("stall_hold[%0d]", idx),
                          {burst_valid_o, burst_src_addr_o, burst_dst_addr_o, burst_len_o, burst_last_o},
                          {1'b1, got});
                end
                burst_ready_i = 1'b1;
            end
            e = exp_q.pop_front();
            check($sformatf("burst[%0d]", idx), got, e);
            idx++;
            @(negedge clk);
        end
        check("idle_after_transfer", {burst_valid_o, busy_o, req_ready_o}, 3'b001);
    endtask

    // ---------------- test ----------------
    vec_t vec[5];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r;
        logic [31:0] tmp;
        int stall;

        // Directed vectors.
        vec[0] = '{req: mk_req(32'h0, 32'h0, 32'h100, 0, 0, 0, 0, 0, 0), n: 2'd1,
                   exp: {{W{1'b0}}, mk_burst(32'h0, 32'h0, 32'h100, 1)}, stall: 8'd0};
        vec[1] = '{req: mk_req(32'h3F0, 32'h1000, 32'h40, 0, 0, 0, 0, 0, 0), n: 2'd2,
                   exp: {mk_burst(32'h400, 32'h1010, 32'h30, 1), mk_burst(32'h3F0, 32'h1000, 32'h10, 0)},
                   stall: 8'd0};
        vec[2] = '{req: mk_req(32'h0, 32'h8, 32'h20, 0, 1, 3'd2, 0, 0, 0), n: 2'd2,
                   exp: {mk_burst(32'h10, 32'h18, 32'h10, 1), mk_burst(32'h0, 32'h8, 32'h10, 0)},
                   stall: 8'd0};
        vec[3] = '{req: mk_req(32'h2, 32'h100, 32'h6, 1, 0, 0, 0, 0, 0), n: 2'd2,
                   exp: {mk_burst(32'h4, 32'h102, 32'h4, 1), mk_burst(32'h2, 32'h100, 32'h2, 0)},
                   stall: 8'd0};
        vec[4] = vec[1];
        vec[4].stall = 8'd5;

        // Reset state.
        @(negedge clk);
        check("reset_outputs",
              {req_ready_o, burst_valid_o, busy_o, burst_src_addr_o, burst_dst_addr_o, burst_len_o, burst_last_o},
              '0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {req_ready_o, burst_valid_o, busy_o}, 3'b100);

        for (int i = 0; i < 5; i++) begin
            exp_q.delete();
            for (int k = 0; k < int'(vec[i].n); k++) exp_q.push_back(vec[i].exp[k]);
            send_req(vec[i].req);
            collect(int'(vec[i].stall));
        end

        // Zero-length request: consumed, nothing emitted.
        send_req(mk_req(32'h40, 32'h80, 32'h0, 0, 0, 0, 0, 0, 0));
        check("len0_idle", {burst_valid_o, busy_o, req_ready_o}, 3'b001);
        @(negedge clk);
        check("len0_still_idle", {burst_valid_o, busy_o, req_ready_o}, 3'b001);

        // Reset in the middle of a two-burst transfer.
        exp_q.delete();
        send_req(vec[1].req);
        check("pre_reset_burst0", {burst_valid_o, burst_src_addr_o, burst_len_o}, {1'b1, 32'h3F0, 32'h10});
        @(negedge clk);
        check("pre_reset_burst1", {burst_valid_o, burst_src_addr_o, burst_len_o}, {1'b1, 32'h400, 32'h30});
        rst_i = 1'b1;
        #1;
        check("during_reset",
              {req_ready_o, burst_valid_o, busy_o, burst_src_addr_o, burst_dst_addr_o, burst_len_o, burst_last_o},
              '0);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("after_reset_idle", {burst_valid_o, busy_o, req_ready_o, dbg_state_o}, {3'b001, IDLE});
        @(negedge clk);
        check("no_burst_after_reset", {burst_valid_o, busy_o}, 2'b00);
        exp_q.push_back(vec[0].exp[0]);
        send_req(vec[0].req);
        collect(0);

        // Randomized transfers against the reference model.
        for (int t = 0; t < 60; t++) begin
            tmp = $urandom();
            r.src = (t % 8 == 7) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 255)) : tmp;
            tmp = $urandom();
            r.dst = tmp;
            r.len = (t % 15 == 14) ? 32'h0 : 32'($urandom_range(1, 300));
            r.snb = ($urandom_range(0, 5) == 0);
            r.srl = $urandom_range(0, 1) == 1;
            r.sml = 3'($urandom_range(0, 7));
            r.dnb = ($urandom_range(0, 5) == 0);
            r.drl = $urandom_range(0, 1) == 1;
            r.dml = 3'($urandom_range(0, 7));
            stall = $urandom_range(0, 2);
            exp_q.delete();
            model(r);
            send_req(r);
            if (r.len == 0) check("rand_len0_idle", {burst_valid_o, busy_o, req_ready_o}, 3'b001);
            else collect(stall);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
